// File: rtl/oclib_csr_splitter.sv
// CSR fan-out: routes each initiator transaction to the target picked by an address field,
// with timeout, error responses for unmapped/illegal requests and a saturating error count.
module oclib_csr_splitter #(
    parameter int unsigned NumTargets      = 4,
    parameter int unsigned AddressWidth    = 32,
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned SelectLsb       = 16,
    parameter int unsigned TimeoutCycles   = 1024,
    parameter int unsigned ErrorCountWidth = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            inRead,
    input  logic                            inWrite,
    input  logic [AddressWidth-1:0]         inAddress,
    input  logic [DataWidth-1:0]            inWdata,
    output logic                            inReady,
    output logic                            inError,
    output logic [DataWidth-1:0]            inRdata,
    output logic [NumTargets-1:0]           outRead,
    output logic [NumTargets-1:0]           outWrite,
    output logic [AddressWidth-1:0]         outAddress,
    output logic [DataWidth-1:0]            outWdata,
    input  logic [NumTargets-1:0]           outReady,
    input  logic [NumTargets-1:0]           outError,
    input  logic [NumTargets*DataWidth-1:0] outRdata,
    output logic                            busy,
    output logic [ErrorCountWidth-1:0]      errorCount
);

    localparam int unsigned SelectBits = (NumTargets > 1) ? $clog2(NumTargets) : 1;
    localparam int unsigned TimerWidth = $clog2(TimeoutCycles);
    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);
    localparam logic [SelectBits:0] NumTargetsW = (SelectBits + 1)'(NumTargets);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StRespond
    } stateT;

    stateT                      stateQ, stateD;
    logic [NumTargets-1:0]      selQ;
    logic [NumTargets-1:0]      outReadQ, outWriteQ;
    logic [AddressWidth-1:0]    outAddressQ;
    logic [DataWidth-1:0]       outWdataQ;
    logic [TimerWidth-1:0]      timerQ;
    logic                       inErrorQ;
    logic [DataWidth-1:0]       inRdataQ;
    logic [ErrorCountWidth-1:0] errorCountQ;

    logic [SelectBits-1:0]      reqSel;
    logic [NumTargets-1:0]      reqOneHot;
    logic                       reqValid, reqIllegal, reqUnmapped;
    logic                       ackHit, ackErr;
    logic [DataWidth-1:0]       ackRdata;
    logic                       startTxn, respondNow, respError;
    logic [DataWidth-1:0]       respRdata;

    assign reqSel      = inAddress[SelectLsb +: SelectBits];
    assign reqValid    = inRead | inWrite;
    assign reqIllegal  = inRead & inWrite;
    assign reqUnmapped = ({1'b0, reqSel} >= NumTargetsW);

    always_comb begin
        reqOneHot = '0;
        for (int i = 0; i < NumTargets; i++) begin
            reqOneHot[i] = (reqSel == SelectBits'(i));
        end
    end

    // Only the latched target's lanes matter; everything else is masked off.
    assign ackHit = |(outReady & selQ);
    assign ackErr = |(outReady & outError & selQ);

    always_comb begin
        ackRdata = '0;
        for (int i = 0; i < NumTargets; i++) begin
            if (selQ[i]) begin
                ackRdata = outRdata[i*DataWidth +: DataWidth];
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state and response decision
    always_comb begin
        stateD     = stateQ;
        startTxn   = 1'b0;
        respondNow = 1'b0;
        respError  = 1'b0;
        respRdata  = '0;
        unique case (stateQ)
            StIdle: begin
                if (reqValid) begin
                    if (reqIllegal || reqUnmapped) begin
                        stateD     = StRespond;
                        respondNow = 1'b1;
                        respError  = 1'b1;
                    end else begin
                        stateD   = StWait;
                        startTxn = 1'b1;
                    end
                end
            end
            StWait: begin
                // An ack in the expiry cycle takes priority over the timeout.
                if (ackHit) begin
                    stateD     = StRespond;
                    respondNow = 1'b1;
                    respError  = ackErr;
                    respRdata  = (|outReadQ) ? ackRdata : '0;
                end else if (timerQ == TimerLast) begin
                    stateD     = StRespond;
                    respondNow = 1'b1;
                    respError  = 1'b1;
                end
            end
            StRespond: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        inReady = (stateQ == StRespond);
        busy    = (stateQ != StIdle);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            selQ        <= '0;
            outReadQ    <= '0;
            outWriteQ   <= '0;
            outAddressQ <= '0;
            outWdataQ   <= '0;
            timerQ      <= '0;
            inErrorQ    <= 1'b0;
            inRdataQ    <= '0;
            errorCountQ <= '0;
        end else begin
            if (startTxn) begin
                selQ        <= reqOneHot;
                outAddressQ <= inAddress;
                outWdataQ   <= inWdata;
                outReadQ    <= inRead ? reqOneHot : '0;
                outWriteQ   <= inWrite ? reqOneHot : '0;
                timerQ      <= '0;
            end else if (stateQ == StWait) begin
                timerQ <= timerQ + 1'b1;
            end
            if (respondNow) begin
                outReadQ  <= '0;
                outWriteQ <= '0;
                inErrorQ  <= respError;
                inRdataQ  <= respRdata;
                if (respError && (errorCountQ != '1)) begin
                    errorCountQ <= errorCountQ + 1'b1;
                end
            end
        end
    end

    assign outRead    = outReadQ;
    assign outWrite   = outWriteQ;
    assign outAddress = outAddressQ;
    assign outWdata   = outWdataQ;
    assign inError    = inErrorQ;
    assign inRdata    = inRdataQ;
    assign errorCount = errorCountQ;

endmodule

// File: tb/tb_oclib_csr_splitter.sv
// Randomized scoreboard bench for oclib_csr_splitter: a responder emulates the targets and a
// monitor checks every initiator response against a queue of modelled results.
module tb_oclib_csr_splitter;

    localparam int unsigned NumTargets      = 3;
    localparam int unsigned AddressWidth    = 32;
    localparam int unsigned DataWidth       = 32;
    localparam int unsigned SelectLsb       = 16;
    localparam int unsigned TimeoutCycles   = 8;
    localparam int unsigned ErrorCountWidth = 2;

    logic                            clock = 1'b0;
    logic                            reset;
    logic                            inRead, inWrite;
    logic [AddressWidth-1:0]         inAddress;
    logic [DataWidth-1:0]            inWdata;
    logic                            inReady, inError;
    logic [DataWidth-1:0]            inRdata;
    logic [NumTargets-1:0]           outRead, outWrite;
    logic [AddressWidth-1:0]         outAddress;
    logic [DataWidth-1:0]            outWdata;
    logic [NumTargets-1:0]           outReady, outError;
    logic [NumTargets*DataWidth-1:0] outRdata;
    logic                            busy;
    logic [ErrorCountWidth-1:0]      errorCount;

    oclib_csr_splitter #(
        .NumTargets     (NumTargets),
        .AddressWidth   (AddressWidth),
        .DataWidth      (DataWidth),
        .SelectLsb      (SelectLsb),
        .TimeoutCycles  (TimeoutCycles),
        .ErrorCountWidth(ErrorCountWidth)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .inRead    (inRead),
        .inWrite   (inWrite),
        .inAddress (inAddress),
        .inWdata   (inWdata),
        .inReady   (inReady),
        .inError   (inError),
        .inRdata   (inRdata),
        .outRead   (outRead),
        .outWrite  (outWrite),
        .outAddress(outAddress),
        .outWdata  (outWdata),
        .outReady  (outReady),
        .outError  (outError),
        .outRdata  (outRdata),
        .busy      (busy),
        .errorCount(errorCount)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [1:0]  count;
    } respT;

    respT expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   modelCount = 0;

    // Current transaction context shared with the target responder.
    int          curSel = 0;
    bit          curIsRead = 1'b0;
    int          curAckDelay = 99;
    bit          curAckErr = 1'b0;
    logic [31:0] curAckData = '0;
    logic [31:0] curAddr = '0;
    logic [31:0] curWdata = '0;
    int          curStrobeLen = 0;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    // Monitor: every inReady pulse must match the oldest expected response.
    always @(negedge clock) begin
        respT e;
        if (inReady === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response: got inReady=1, expected no response");
            end else begin
                e = expQ.pop_front();
                check("resp_error", inError, e.err);
                check("resp_rdata", inRdata, e.rdata);
                check("resp_error_count", errorCount, e.count);
            end
        end
    end

    // Target responder with noise on non-selected lanes.
    logic [NumTargets-1:0] prevStrobe = '0;
    bit active = 1'b0;
    bit lenDone = 1'b0;
    int cnt = 0;
    int strobeLen = 0;

    always @(negedge clock) begin
        logic [NumTargets-1:0] strobe;
        logic [NumTargets-1:0] noise;
        strobe = outRead | outWrite;
        noise  = NumTargets'($urandom_range(0, 7) & $urandom_range(0, 7));
        for (int i = 0; i < NumTargets; i++) begin
            outRdata[i*DataWidth +: DataWidth] = $urandom;
            outError[i] = 1'($urandom_range(0, 1));
            outReady[i] = (i != curSel) ? noise[i] : 1'b0;
        end
        if (reset) begin
            active = 1'b0;
        end else begin
            if (strobe != '0 && prevStrobe == '0) begin
                active    = 1'b1;
                cnt       = 0;
                strobeLen = 0;
                lenDone   = 1'b0;
                check("strobe_onehot", strobe, 64'(1 << curSel));
                check("strobe_kind", {|outRead, |outWrite}, curIsRead ? 2'b10 : 2'b01);
                check("out_address", outAddress, curAddr);
                check("out_wdata", outWdata, curWdata);
            end
            if (active) begin
                if (strobe != '0) begin
                    strobeLen++;
                end else if (!lenDone) begin
                    lenDone = 1'b1;
                    if (curStrobeLen != 0) check("strobe_length", strobeLen, curStrobeLen);
                end
                if (cnt == curAckDelay && curSel < NumTargets) begin
                    outReady[curSel] = 1'b1;
                    outError[curSel] = curAckErr;
                    outRdata[curSel*DataWidth +: DataWidth] = curAckData;
                end
                cnt++;
                if (cnt > 11) active = 1'b0;
            end
        end
        prevStrobe = strobe;
    end

    // kind: 0 read, 1 write, 2 both. ackDelay counts cycles after the first strobe cycle.
    task automatic runTxn(input logic [31:0] addr, input int kind, input int ackDelay,
                          input bit ackErr, input logic [31:0] ackData,
                          input logic [31:0] wdata);
        int   sel;
        bit   bad;
        int   expLat;
        int   cyc;
        respT e;
        sel = int'(addr[SelectLsb +: 2]);
        bad = (kind == 2) || (sel >= NumTargets);
        if (bad) begin
            e.err = 1'b1; e.rdata = '0; expLat = 1;
        end else if (ackDelay <= int'(TimeoutCycles) - 1) begin
            e.err = ackErr; e.rdata = (kind == 0) ? ackData : '0; expLat = 2 + ackDelay;
        end else begin
            e.err = 1'b1; e.rdata = '0; expLat = int'(TimeoutCycles) + 1;
        end
        if (e.err && modelCount < 3) modelCount++;
        e.count = 2'(modelCount);
        expQ.push_back(e);

        curSel       = sel;
        curIsRead    = (kind == 0);
        curAckDelay  = ackDelay;
        curAckErr    = ackErr;
        curAckData   = ackData;
        curAddr      = addr;
        curWdata     = wdata;
        curStrobeLen = bad ? 0 : ((ackDelay < int'(TimeoutCycles)) ? ackDelay
                                                                   : int'(TimeoutCycles) - 1) + 1;
        inRead    = (kind != 1);
        inWrite   = (kind != 0);
        inAddress = addr;
        inWdata   = wdata;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (inReady !== 1'b1 && cyc < 40);
        check("latency", cyc, expLat);
        inRead  = 1'b0;
        inWrite = 1'b0;
        repeat (3 + $urandom_range(0, 2)) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        inRead    = 1'b0;
        inWrite   = 1'b0;
        inAddress = '0;
        inWdata   = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_inReady", inReady, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_errorCount", errorCount, 2'd0);
        check("reset_strobes", {outRead, outWrite}, '0);
        check("reset_outAddress", outAddress, '0);
        check("reset_inRdata", {inError, inRdata}, '0);

        runTxn(32'h0002_0010, 0, 3, 1'b0, 32'hA5A5_0001, 32'h0);
        runTxn(32'h0000_0004, 1, 0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
        runTxn(32'h0003_0000, 0, 0, 1'b0, 32'h0, 32'h0);
        runTxn(32'h0001_0000, 2, 0, 1'b0, 32'h0, 32'h0);
        runTxn(32'h0001_0020, 0, 9, 1'b0, 32'h5555_AAAA, 32'h0);
        runTxn(32'h0002_0030, 0, 7, 1'b0, 32'h0BAD_F00D, 32'h0);

        for (int n = 0; n < 150; n++) begin
            int r;
            int kind;
            r    = $urandom_range(0, 9);
            kind = (r < 4) ? 0 : ((r < 8) ? 1 : 2);
            runTxn($urandom, kind, $urandom_range(0, 10), ($urandom_range(0, 3) == 0),
                   $urandom, $urandom);
        end

        // Reset two cycles into Wait: no response may follow and the counter clears.
        curSel       = 1;
        curIsRead    = 1'b1;
        curAckDelay  = 99;
        curStrobeLen = 0;
        curAddr      = 32'h0001_0040;
        curWdata     = 32'h0000_0077;
        inRead       = 1'b1;
        inAddress    = curAddr;
        inWdata      = curWdata;
        @(negedge clock);
        @(negedge clock);
        check("wait_busy", busy, 1'b1);
        check("wait_outRead", outRead, 3'b010);
        reset  = 1'b1;
        inRead = 1'b0;
        @(negedge clock);
        check("midreset_outRead", outRead, 3'b000);
        check("midreset_inReady", inReady, 1'b0);
        check("midreset_busy", busy, 1'b0);
        check("midreset_errorCount", errorCount, 2'd0);
        reset      = 1'b0;
        modelCount = 0;
        @(negedge clock);
        runTxn(32'h0001_0044, 0, 2, 1'b0, 32'hCAFE_0002, 32'h0);

        // Five unmapped requests walk the counter to saturation.
        for (int n = 0; n < 5; n++) begin
            runTxn(32'h0003_0000 | 32'(n * 4), 0, 0, 1'b0, 32'h0, 32'h0);
        end

        repeat (4) @(negedge clock);
        check("queue_drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
